// File: rtl/qpp_interleaver_buffer.sv
// Turbo-encoder block interleaver: stores K bits in natural order, replays them in
// QPP order pi(i) = (f1*i + f2*i^2) mod K using an add-only address recursion.
module qpp_interleaver_buffer #(
    parameter int KMAX = 6144,
    parameter int KMIN = 40,
    parameter int AW   = 13
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          blk_start,
    input  logic [AW-1:0] blk_k,
    input  logic [AW-1:0] f1,
    input  logic [AW-1:0] f2,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    output logic          out_valid,
    output logic          out_bit,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          cfg_err
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d, f1_q, f1_d, f2_q, f2_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] pi_q, pi_d, g_q, g_d, d_q, d_d;
    logic          rd_done_q, rd_done_d, in_ready_q, in_ready_d;
    logic          busy_q, busy_d, cfg_err_q, cfg_err_d;
    logic          rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic          out_valid_q, out_valid_d, out_bit_q, out_bit_d, out_last_q, out_last_d;
    logic          skid_valid_q, skid_valid_d, skid_bit_q, skid_bit_d, skid_last_q, skid_last_d;

    logic          ram [KMAX];
    logic          rdata_q;
    logic          rd_en, wr_en, pop, cfg_ok, last_wr;
    logic [AW-1:0] rd_addr, g0, d0;

    // (a + b) mod m for a, b < m: one conditional subtract on an AW+1 bit sum.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [AW-1:0] m);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[AW-1:0];
    endfunction

    assign cfg_ok  = (blk_k >= AW'(KMIN)) && (blk_k <= AW'(KMAX)) && (f1 < blk_k) && (f2 < blk_k);
    assign wr_en   = (state_q == FILL) && in_valid && in_ready_q;
    assign last_wr = wr_en && (wr_cnt_q == k_q - AW'(1));
    assign pop     = out_valid_q && out_ready;
    assign g0      = mod_add(f1_q, f2_q, k_q);
    assign d0      = mod_add(f2_q, f2_q, k_q);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        f1_d         = f1_q;
        f2_d         = f2_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        pi_d         = pi_q;
        g_d          = g_q;
        d_d          = d_q;
        rd_done_d    = rd_done_q;
        in_ready_d   = in_ready_q;
        cfg_err_d    = 1'b0;
        rvalid_d     = 1'b0;
        rlast_d      = rlast_q;
        out_valid_d  = out_valid_q;
        out_bit_d    = out_bit_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_bit_d   = skid_bit_q;
        skid_last_d  = skid_last_q;
        rd_en        = 1'b0;
        rd_addr      = pi_q;

        // Output stage: a read result lands in the output register when it is free,
        // otherwise in the skid register, so an in-flight read is never dropped.
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_bit_d    = skid_bit_q;
                out_last_d   = skid_last_q;
                skid_valid_d = rvalid_q;
                skid_bit_d   = rdata_q;
                skid_last_d  = rlast_q;
            end else if (rvalid_q) begin
                out_valid_d = 1'b1;
                out_bit_d   = rdata_q;
                out_last_d  = rlast_q;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (rvalid_q) begin
            skid_valid_d = 1'b1;
            skid_bit_d   = rdata_q;
            skid_last_d  = rlast_q;
        end

        case (state_q)
            IDLE: begin
                if (blk_start) begin
                    if (cfg_ok) begin
                        k_d        = blk_k;
                        f1_d       = f1;
                        f2_d       = f2;
                        wr_cnt_d   = '0;
                        in_ready_d = 1'b1;
                        state_d    = FILL;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (last_wr) begin
                    // pi(0) = 0 is read in the same cycle the final bit is written
                    // (K >= KMIN keeps address 0 distinct from K-1), saving a cycle.
                    in_ready_d = 1'b0;
                    state_d    = DRAIN;
                    wr_cnt_d   = '0;
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                    rvalid_d   = 1'b1;
                    rlast_d    = 1'b0;
                    pi_d       = g0;
                    g_d        = mod_add(g0, d0, k_q);
                    d_d        = d0;
                    rd_cnt_d   = AW'(1);
                    rd_done_d  = 1'b0;
                end else if (wr_en) begin
                    wr_cnt_d = wr_cnt_q + AW'(1);
                end
            end
            DRAIN: begin
                // Issue only if the skid slot is guaranteed free when the data returns.
                if (!rd_done_q && !skid_valid_d) begin
                    rd_en    = 1'b1;
                    rd_addr  = pi_q;
                    rvalid_d = 1'b1;
                    rlast_d  = (rd_cnt_q == k_q - AW'(1));
                    pi_d     = mod_add(pi_q, g_q, k_q);
                    g_d      = mod_add(g_q, d_q, k_q);
                    if (rd_cnt_q == k_q - AW'(1))
                        rd_done_d = 1'b1;
                    else
                        rd_cnt_d = rd_cnt_q + AW'(1);
                end
                if (pop && out_last_q) begin
                    state_d  = IDLE;
                    rd_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            f1_q         <= '0;
            f2_q         <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            pi_q         <= '0;
            g_q          <= '0;
            d_q          <= '0;
            rd_done_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_bit_q   <= 1'b0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            f1_q         <= f1_d;
            f2_q         <= f2_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            pi_q         <= pi_d;
            g_q          <= g_d;
            d_q          <= d_d;
            rd_done_q    <= rd_done_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            out_valid_q  <= out_valid_d;
            out_bit_q    <= out_bit_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_bit_q   <= skid_bit_d;
            skid_last_q  <= skid_last_d;
        end
    end

    // Bit RAM with registered read; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_cnt_q] <= in_bit;
        if (rd_en)
            rdata_q <= ram[rd_addr];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_qpp_interleaver_buffer.sv
// Randomized bench for qpp_interleaver_buffer: each block's output is compared
// against c(pi(i)) computed directly from the QPP formula.
module tb_qpp_interleaver_buffer;

    localparam int KMAX = 6144;
    localparam int KMIN = 40;
    localparam int AW   = 13;

    logic          clk = 1'b0;
    logic          aclr_n;
    logic          blk_start;
    logic [AW-1:0] blk_k, f1, f2;
    logic          in_valid, in_bit, in_ready;
    logic          out_valid, out_bit, out_last, out_ready;
    logic          busy, cfg_err;

    int n_vec = 0;
    int n_err = 0;

    bit data_mem [KMAX];
    bit exp_mem  [KMAX];

    always #5 clk = ~clk;

    qpp_interleaver_buffer #(.KMAX(KMAX), .KMIN(KMIN), .AW(AW)) dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .blk_start (blk_start),
        .blk_k     (blk_k),
        .f1        (f1),
        .f2        (f2),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int qpp(input int k, input int a, input int b, input int i);
        longint t;
        t = (longint'(a) * i + longint'(b) * i * i) % k;
        return int'(t);
    endfunction

    // Called at a negedge; returns one negedge later with blk_start released.
    task automatic start_block(input int k, input int f1v, input int f2v);
        blk_start = 1'b1;
        blk_k     = AW'(k);
        f1        = AW'(f1v);
        f2        = AW'(f2v);
        @(negedge clk);
        blk_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
    endtask

    task automatic cfg_bad(input int k, input int f1v, input int f2v);
        blk_start = 1'b1;
        blk_k     = AW'(k);
        f1        = AW'(f1v);
        f2        = AW'(f2v);
        @(negedge clk);
        blk_start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_busy", busy, 0);
        check("cfg_in_ready", in_ready, 0);
        @(negedge clk);
        check("cfg_err_once", cfg_err, 0);
        check("cfg_busy2", busy, 0);
        $display("cfg reject K=%0d f1=%0d f2=%0d", k, f1v, f2v);
    endtask

    task automatic run_block(input int k, input int f1v, input int f2v, input bit data_rnd,
                             input bit rdy_rnd, input bit vld_rnd, input bit poke);
        int  wr, rd, cyc, acc_cyc, first_cyc;
        bit  prev_stall, saw_err, done, poked;
        for (int i = 0; i < k; i++)
            data_mem[i] = data_rnd ? 1'($urandom_range(0, 1)) : i[0];
        for (int i = 0; i < k; i++)
            exp_mem[i] = data_mem[qpp(k, f1v, f2v, i)];
        start_block(k, f1v, f2v);
        wr = 0; rd = 0; cyc = 0; acc_cyc = -1; first_cyc = -1;
        prev_stall = 0; saw_err = 0; done = 0; poked = 0;
        while (!done && cyc < 4 * k + 200) begin
            if (cfg_err) saw_err = 1;
            if (prev_stall) check("hold_valid", out_valid, 1);
            if (acc_cyc >= 0 && cyc == acc_cyc + 1) begin
                check("in_ready_drop", in_ready, 0);
                check("no_early_valid", out_valid, 0);
            end
            if (out_valid && first_cyc < 0) begin
                first_cyc = cyc;
                check("first_latency", cyc - acc_cyc, 2);
            end
            if (out_valid && rd < k) begin
                check("out_bit", out_bit, exp_mem[rd]);
                check("out_last", out_last, (rd == k - 1) ? 1 : 0);
            end
            if (rd == k) begin
                check("end_busy", busy, 0);
                check("end_valid", out_valid, 0);
                done = 1;
            end else begin
                if (poke && !poked && wr == 10) begin
                    blk_start = 1'b1;
                    blk_k     = AW'(39);
                    poked     = 1;
                end else begin
                    blk_start = 1'b0;
                end
                in_valid = (wr < k) && (vld_rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
                in_bit   = (wr < k) ? data_mem[wr] : 1'b0;
                if (in_valid && in_ready) begin
                    if (wr == k - 1) acc_cyc = cyc;
                    wr++;
                end
                out_ready  = rdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                prev_stall = out_valid && !out_ready;
                if (out_valid && out_ready) rd++;
                @(negedge clk);
                cyc++;
            end
        end
        check("block_done", done, 1);
        check("no_cfg_err", saw_err, 0);
        in_valid  = 1'b0;
        blk_start = 1'b0;
        $display("block K=%0d f1=%0d f2=%0d: %0d in, %0d out, %0d cycles", k, f1v, f2v, wr, rd, cyc);
    endtask

    initial begin
        aclr_n = 1'b0; blk_start = 1'b0; blk_k = '0; f1 = '0; f2 = '0;
        in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        aclr_n = 1'b1;
        @(negedge clk);

        run_block(40, 3, 10, 0, 0, 0, 0);

        cfg_bad(39, 3, 10);
        cfg_bad(6145, 3, 10);
        cfg_bad(40, 3, 40);

        run_block(40, 3, 10, 1, 1, 1, 0);
        run_block(120, 11, 30, 1, 1, 1, 0);

        // Abandon a block part-way through filling.
        start_block(40, 3, 10);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        aclr_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_bit", out_bit, 0);
        @(negedge clk);
        in_valid = 1'b0;
        aclr_n   = 1'b1;
        @(negedge clk);
        $display("reset at input index 20 of K=40");
        run_block(40, 3, 10, 1, 0, 0, 0);

        run_block(40, 3, 10, 1, 0, 0, 1);
        run_block(48, 7, 12, 1, 0, 0, 0);

        run_block(KMAX, 263, 480, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
